// File: rtl/shift_multiply.sv
`default_nettype none
// ============================================================================
// Module      : shift_multiply
// Description : Sequential sign-magnitude shift-and-add multiplier.
//               Handles one multiplier bit per clock, LSB first. A zero
//               operand magnitude skips the shift phase. Results are
//               registered on entry to FIN and held until the next LOAD.
// Ports       : clk      - clock, rising edge
//               RST      - synchronous active-high reset
//               INn1     - multiplicand, sign-magnitude, WIDTH bits
//               INn2     - multiplier, sign-magnitude, WIDTH bits
//               start    - level request, must drop to leave FIN
//               out      - truncated product, sign-magnitude, WIDTH bits
//               outWide  - full product, sign at MSB, 2*WIDTH-1 bits
//               overflow - full magnitude does not fit in WIDTH-1 bits
//               busy     - high in LOAD and SHIFT
//               finish   - result valid, high only in FIN
// Revision    : 1.0 - initial release
// ============================================================================
module shift_multiply #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     INn1,
    input  logic [WIDTH-1:0]     INn2,
    input  logic                 start,
    output logic [WIDTH-1:0]     out,
    output logic [2*WIDTH-2:0]   outWide,
    output logic                 overflow,
    output logic                 busy,
    output logic                 finish
);

    localparam int MW = WIDTH - 1;        // magnitude width
    localparam int PW = 2 * MW;           // full product magnitude width
    localparam int CW = $clog2(WIDTH);    // counter holds 0..WIDTH-2

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [MW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            load_res;

    logic [WIDTH-1:0]   out_d;
    logic [2*WIDTH-2:0] wide_d;
    logic               ovf_d;
    logic [MW-1:0]      w_trunc;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        load_res = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                mcand_d  = {{MW{1'b0}}, INn1[MW-1:0]};
                mplier_d = INn2[MW-1:0];
                sign_d   = INn1[WIDTH-1] ^ INn2[WIDTH-1];
                acc_d    = '0;
                cnt_d    = '0;
                // A zero magnitude (including -0) gives a zero product, so
                // the cleared accumulator is already the final result.
                if ((INn1[MW-1:0] == '0) || (INn2[MW-1:0] == '0)) begin
                    state_d  = S_FIN;
                    load_res = 1'b1;
                end else begin
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Always runs the full WIDTH-1 bits; the final sum is
                // captured into the result registers on the same edge.
                if (cnt_q == C_LAST) begin
                    state_d  = S_FIN;
                    load_res = 1'b1;
                end
            end
            S_FIN: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result formatting from the accumulator value about to be stored;
    // the sign is suppressed whenever its magnitude is zero.
    always_comb begin
        w_trunc = acc_d[MW-1:0];
        out_d   = {sign_d & (|w_trunc), w_trunc};
        wide_d  = {sign_d & (|acc_d), acc_d};
        ovf_d   = |acc_d[PW-1:MW];
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            out      <= '0;
            outWide  <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            if (load_res) begin
                out      <= out_d;
                outWide  <= wide_d;
                overflow <= ovf_d;
            end
        end
    end

    assign busy   = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign finish = (state_q == S_FIN);

endmodule
`default_nettype wire
